instr_fetch: RTL and testbench

- Fetch stage directly upstream of the instruction ROM (256 x 16-bit, combinational read, 8-bit address).
- Owns the program counter and drives the ROM address. Registers the returned instruction into an instruction register (IR) with a valid flag for the decode stage.
- Supports decode-side stall, branch/jump redirect with flush, and a halt state entered when a HALT opcode is fetched.

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 86 ++++++++
 tb/tb_instr_fetch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: the ROM address/data pair, decode-side controls and the IR outputs.
// The master side is the fetch unit; the slave side is the ROM plus decode.
interface instr_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               stall;
  logic               branch_en;
  logic [ADDR_W-1:0]  branch_target;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic [ADDR_W-1:0]  pc;
  logic               halted;

  modport master (
    output rom_addr, ir, ir_pc, ir_valid, pc, halted,
    input  rom_data, stall, branch_en, branch_target
  );

  modport slave (
    input  rom_addr, ir, ir_pc, ir_valid, pc, halted,
    output rom_data, stall, branch_en, branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the combinational ROM and registers the
// returned word into the IR. Supports stall, branch redirect with flush, and HALT.
module instr_fetch #(
  parameter int               ADDR_W   = 8,
  parameter int               INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_if.master      bus
);

  typedef enum logic {RUN, HALT} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               is_halt_op;

  assign is_halt_op = (bus.rom_data[INSTR_W-1 -: 4] == HALT_OP);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order of statements or processes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // NOTE: every signal gets a hold default before any branch, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    if (bus.branch_en) begin
      // Redirect wins over stall and halt; the IR contents are flushed, not replaced.
      pc_d       = bus.branch_target;
      ir_valid_d = 1'b0;
      state_d    = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (!bus.stall) begin
            ir_d       = bus.rom_data;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (is_halt_op) state_d = HALT;
            else            pc_d    = pc_q + ADDR_W'(1);
          end
        end
        HALT: begin
          // A stalled decode keeps the pending HALT word until it is accepted.
          if (!bus.stall) ir_valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    bus.rom_addr = pc_q;
    bus.pc       = pc_q;
    bus.ir       = ir_q;
    bus.ir_pc    = ir_pc_q;
    bus.ir_valid = ir_valid_q;
    bus.halted   = (state_q == HALT);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a behavioural 256x16 ROM, hand-computed expectations,
// sampling and driving on the falling edge.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] rom [256];

  instr_fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  instr_fetch #(
    .ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00), .HALT_OP(4'hF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = rom[bus.rom_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ir(input string tag, input logic [15:0] ir, input logic [7:0] ir_pc,
                          input logic valid, input logic [7:0] pc);
    check({tag, ".ir"},       32'(bus.ir),       32'(ir));
    check({tag, ".ir_pc"},    32'(bus.ir_pc),    32'(ir_pc));
    check({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(valid));
    check({tag, ".pc"},       32'(bus.pc),       32'(pc));
    check({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(pc));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h1001;
    rom[8'h01] = 16'h2002;
    rom[8'h02] = 16'h3003;
    rom[8'h03] = 16'h4004;
    rom[8'h05] = 16'hF000;
    rom[8'h10] = 16'h7010;
    rom[8'h40] = 16'h4040;
    rom[8'hFF] = 16'h1234;

    reset = 1'b1;
    bus.stall = 1'b0;
    bus.branch_en = 1'b0;
    bus.branch_target = 8'h00;
    @(negedge clk);
    step();
    reset = 1'b0;

    // Reset state
    check_ir("reset", 16'h0000, 8'h00, 1'b0, 8'h00);
    check("reset.halted", 32'(bus.halted), 32'd0);

    // Free run
    step();
    check_ir("run1", 16'h1001, 8'h00, 1'b1, 8'h01);
    step();
    check_ir("run2", 16'h2002, 8'h01, 1'b1, 8'h02);

    // Stall holds everything
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ir($sformatf("stall%0d", i), 16'h2002, 8'h01, 1'b1, 8'h02);
    end
    bus.stall = 1'b0;
    step();
    check_ir("unstall", 16'h3003, 8'h02, 1'b1, 8'h03);

    // Branch with simultaneous stall; rom_addr must not react before the edge
    bus.branch_en = 1'b1;
    bus.branch_target = 8'h40;
    bus.stall = 1'b1;
    #1;
    check("no_comb_path", 32'(bus.rom_addr), 32'h03);
    step();
    check_ir("branch", 16'h3003, 8'h02, 1'b0, 8'h40);
    bus.branch_en = 1'b0;
    bus.stall = 1'b0;
    step();
    check_ir("branch_fetch", 16'h4040, 8'h40, 1'b1, 8'h41);

    // Wrap-around at FF
    rom[8'h00] = 16'h5678;
    bus.branch_en = 1'b1;
    bus.branch_target = 8'hFF;
    step();
    bus.branch_en = 1'b0;
    check_ir("wrap_br", 16'h4040, 8'h40, 1'b0, 8'hFF);
    step();
    check_ir("wrap_ff", 16'h1234, 8'hFF, 1'b1, 8'h00);
    step();
    check_ir("wrap_00", 16'h5678, 8'h00, 1'b1, 8'h01);

    // Halt: HALT word delivered, stall keeps it valid, then flushed; PC frozen
    bus.branch_en = 1'b1;
    bus.branch_target = 8'h05;
    step();
    bus.branch_en = 1'b0;
    step();
    check_ir("halt_fetch", 16'hF000, 8'h05, 1'b1, 8'h05);
    check("halt_fetch.halted", 32'(bus.halted), 32'd1);
    bus.stall = 1'b1;
    step();
    check_ir("halt_stall", 16'hF000, 8'h05, 1'b1, 8'h05);
    bus.stall = 1'b0;
    step();
    check_ir("halt_drop", 16'hF000, 8'h05, 1'b0, 8'h05);
    for (int i = 0; i < 10; i++) step();
    check_ir("halt_hold", 16'hF000, 8'h05, 1'b0, 8'h05);
    check("halt_hold.halted", 32'(bus.halted), 32'd1);

    // Restart by branch
    bus.branch_en = 1'b1;
    bus.branch_target = 8'h10;
    step();
    bus.branch_en = 1'b0;
    check("restart.halted", 32'(bus.halted), 32'd0);
    check_ir("restart", 16'hF000, 8'h05, 1'b0, 8'h10);
    step();
    check_ir("restart_fetch", 16'h7010, 8'h10, 1'b1, 8'h11);

    // Reset while halted with a valid IR, together with branch and stall
    bus.branch_en = 1'b1;
    bus.branch_target = 8'h05;
    step();
    bus.branch_en = 1'b0;
    step();
    check("pre_reset.halted", 32'(bus.halted), 32'd1);
    reset = 1'b1;
    bus.stall = 1'b1;
    bus.branch_en = 1'b1;
    bus.branch_target = 8'h33;
    step();
    check_ir("mid_reset", 16'h0000, 8'h00, 1'b0, 8'h00);
    check("mid_reset.halted", 32'(bus.halted), 32'd0);
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.branch_en = 1'b0;
    step();
    check_ir("post_reset", 16'h5678, 8'h00, 1'b1, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
